alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  ALU result and control fields valid this cycle.
REQ-005 in_ready  out  1  block can accept a transaction this cycle.
REQ-006 alu_out  in  8  ALU result.
REQ-007 alu_zncv  in  4  ALU flags: bit3 Z, bit2 N, bit1 C, bit0 V.
REQ-008 dest  in  2  00 none, 01 reg A, 10 reg B, 11 memory.
REQ-009 flags_we  in  1  update the status register with alu_zncv.
REQ-010 br_req, br_cond  in  1, 3  branch request and condition code.
REQ-011 reg_a, reg_b  out  8 each  architectural operand registers, fed back to the ALU inputs.
REQ-012 status  out  4  registered ZNCV.
REQ-013 mem_data, mem_we  out  8, 1  memory write data and request; mem_ack  in  1  memory acceptance.
REQ-014 br_taken  out  1  one-cycle branch-taken pulse.
REQ-015 wb_err  out  1  sticky memory-timeout error, present only with the macro in REQ-033.

Function
REQ-016 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-017 The FSM SHALL have the states IDLE and MEM_WAIT; in_ready SHALL be high only in IDLE.
REQ-018 On acceptance with dest 01 or 10, reg_a or reg_b SHALL take alu_out at that edge (visible the next cycle), and the FSM SHALL stay in IDLE.
REQ-019 On acceptance with dest 11, mem_data SHALL latch alu_out, mem_we SHALL go high the next cycle, and the FSM SHALL enter MEM_WAIT.
REQ-020 In MEM_WAIT, mem_we and mem_data SHALL be held stable until a cycle with mem_ack high; at that edge mem_we SHALL drop and the FSM SHALL return to IDLE. Minimum transaction period is 2 cycles.
REQ-021 dest 00 SHALL leave reg_a, reg_b and memory untouched.
REQ-022 On acceptance with flags_we high, status SHALL take alu_zncv; with flags_we low, status SHALL hold.
REQ-023 On acceptance with br_req high, br_taken SHALL pulse for exactly one cycle next cycle when br_cond is true against the status value held before this transaction's update.
REQ-024 br_cond coding: 000 always, 001 EQ Z, 010 NE !Z, 011 GT !Z&!N, 100 GE !N, 101 LT N, 110 LE N|Z, 111 CS C.
REQ-025 Inputs presented while in_ready is low SHALL be ignored, with no state change.
REQ-026 Back-to-back acceptances in IDLE SHALL be sustained at one per cycle for dest 00/01/10.

Reset
REQ-027 While reset is high at a rising edge: reg_a, reg_b, status and mem_data SHALL be 0, mem_we, br_taken and wb_err SHALL be 0, and the FSM SHALL be in IDLE.
REQ-028 Reset SHALL take priority over every other event, including acceptance and mem_ack in the same cycle.
REQ-029 Reset during MEM_WAIT SHALL abandon the pending write (mem_we low the next cycle).
REQ-030 in_ready SHALL be low in any cycle where reset is high.

Configuration
REQ-031 The macro WB_MEM_TIMEOUT_EN SHALL control the timeout feature.
REQ-032 Without WB_MEM_TIMEOUT_EN: MEM_WAIT SHALL wait indefinitely for mem_ack, and wb_err SHALL be constant 0.
REQ-033 With WB_MEM_TIMEOUT_EN: a 4-bit counter SHALL clear on MEM_WAIT entry and increment each cycle in MEM_WAIT without mem_ack; in the 16th such cycle the FSM SHALL return to IDLE, drop mem_we and set wb_err sticky until reset.

Structure
REQ-034 The shared package alu_pkg SHALL hold the dest encodings, the br_cond encodings, the ZNCV bit indices and the FSM state type.
REQ-035 Condition evaluation SHALL be the combinational sub-module cond_eval (inputs status and br_cond, output taken).

Verification
REQ-036 Reset, then accept alu_out=8'h2A, dest=01, flags_we=1, alu_zncv=0000 -> reg_a=8'h2A next cycle, status=0000.
REQ-037 status Z=1, then accept br_req=1, br_cond=001, flags_we=1, alu_zncv=0000 -> br_taken=1 for one cycle, status=0000 afterwards.
REQ-038 Accept alu_out=8'h55, dest=11, mem_ack held low 3 cycles then high -> mem_we high 4 cycles with mem_data=8'h55, in_ready low throughout, then IDLE.
REQ-039 Assert reset in MEM_WAIT coincident with mem_ack=1 -> next cycle all outputs 0, in_ready=1 once reset releases.
REQ-040 With WB_MEM_TIMEOUT_EN, dest=11 and mem_ack held low -> mem_we drops after 16 MEM_WAIT cycles, wb_err=1 and stays 1 until reset.
REQ-041 Three consecutive accepts: dest=10 (8'h01), dest=10 (8'h02), dest=00 (8'hFF) -> reg_b=8'h02 at the end, reg_a unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings and types for the ALU write-back stage.
// Optional feature macro: WB_MEM_TIMEOUT_EN (memory-write timeout with sticky wb_err).
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned DEST_W = 2;
    localparam int unsigned COND_W = 3;
    localparam int unsigned TMO_W  = 4;

    // ZNCV bit positions inside alu_zncv / status
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [DEST_W-1:0] {
        DEST_NONE  = 2'b00,
        DEST_REG_A = 2'b01,
        DEST_REG_B = 2'b10,
        DEST_MEM   = 2'b11
    } dest_e;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_GT = 3'b011,
        COND_GE = 3'b100,
        COND_LT = 3'b101,
        COND_LE = 3'b110,
        COND_CS = 3'b111
    } cond_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator against a ZNCV status word.
module cond_eval
    import alu_pkg::*;
(
    input  logic [FLAG_W-1:0] status,
    input  logic [COND_W-1:0] br_cond,
    output logic              taken
);

    logic z;
    logic n;
    logic c;
    logic unused_v;

    assign z        = status[FLAG_Z];
    assign n        = status[FLAG_N];
    assign c        = status[FLAG_C];
    assign unused_v = status[FLAG_V];

    // Decode the condition code into a taken decision
    always_comb begin
        taken = 1'b0;
        case (cond_e'(br_cond))
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_GT: taken = ~z & ~n;
            COND_GE: taken = ~n;
            COND_LT: taken = n;
            COND_LE: taken = n | z;
            COND_CS: taken = c;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: register/status update, memory write handshake, branch pulse.
// Optional feature macro: WB_MEM_TIMEOUT_EN (abort a stalled memory write after
// 16 wait cycles and raise sticky wb_err; otherwise wb_err is tied low).
module alu_writeback
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_zncv,
    input  logic [DEST_W-1:0] dest,
    input  logic              flags_we,
    input  logic              br_req,
    input  logic [COND_W-1:0] br_cond,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [FLAG_W-1:0] status,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              br_taken,
    output logic              wb_err
);

    wb_state_e state;
    wb_state_e state_next;
    logic      accept;
    logic      cond_taken;
    logic      timeout_hit;

    // Ready is combinational so it drops in the same cycle reset is raised
    assign in_ready = (state == ST_IDLE) & ~reset;
    assign accept   = in_valid & in_ready;

    cond_eval u_cond_eval (
        .status  (status),
        .br_cond (br_cond),
        .taken   (cond_taken)
    );

`ifdef WB_MEM_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    // Sixteenth consecutive wait cycle without an ack ends the write
    assign timeout_hit = (state == ST_MEM_WAIT) & ~mem_ack & (tmo_cnt == TMO_W'(15));

    // Wait-cycle counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            wb_err  <= 1'b0;
        end else begin
            if (state != ST_MEM_WAIT) begin
                tmo_cnt <= '0;
            end else if (!mem_ack) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (timeout_hit) begin
                wb_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign wb_err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && (dest_e'(dest) == DEST_MEM)) begin
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Architectural registers, status, memory request and branch pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a    <= '0;
            reg_b    <= '0;
            status   <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            mem_we   <= (state_next == ST_MEM_WAIT);
            br_taken <= accept & br_req & cond_taken;
            if (accept) begin
                if (flags_we) begin
                    status <= alu_zncv;
                end
                case (dest_e'(dest))
                    DEST_REG_A: reg_a    <= alu_out;
                    DEST_REG_B: reg_b    <= alu_out;
                    DEST_MEM:   mem_data <= alu_out;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_alu_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_out;
    logic [3:0] alu_zncv;
    logic [1:0] dest;
    logic       flags_we;
    logic       br_req;
    logic [2:0] br_cond;
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [3:0] status;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       mem_ack;
    logic       br_taken;
    logic       wb_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_a, m_b, m_mem_data;
    logic [3:0] m_status;
    bit         m_busy, m_err, m_br;
    int         m_wait;

    alu_writeback dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_out  (alu_out),
        .alu_zncv (alu_zncv),
        .dest     (dest),
        .flags_we (flags_we),
        .br_req   (br_req),
        .br_cond  (br_cond),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .status   (status),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .br_taken (br_taken),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch condition as written in the condition-code table
    function automatic bit cond_true(input logic [3:0] st, input logic [2:0] code);
        bit z, n, c;
        z = st[3];
        n = st[2];
        c = st[1];
        case (code)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return !z && !n;
            3'd4: return !n;
            3'd5: return n;
            3'd6: return n || z;
            default: return c;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [7:0] alu, input logic [3:0] zncv,
                         input logic [1:0] d, input bit fwe, input bit brq,
                         input logic [2:0] brc, input bit ack);
        in_valid = v;
        alu_out  = alu;
        alu_zncv = zncv;
        dest     = d;
        flags_we = fwe;
        br_req   = brq;
        br_cond  = brc;
        mem_ack  = ack;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 8'h00, 4'h0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    // Advance one clock: check ready, update model from this cycle's inputs, check outputs
    task automatic step();
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && !reset)});
        @(posedge clk);
        if (reset) begin
            m_a = '0; m_b = '0; m_mem_data = '0; m_status = '0;
            m_busy = 0; m_err = 0; m_br = 0; m_wait = 0;
        end else if (m_busy) begin
            m_br = 0;
            if (mem_ack) begin
                m_busy = 0;
            end else begin
                m_wait++;
`ifdef WB_MEM_TIMEOUT_EN
                if (m_wait == 16) begin
                    m_busy = 0;
                    m_err  = 1;
                end
`endif
            end
        end else begin
            m_br = 0;
            if (in_valid) begin
                m_br = br_req && cond_true(m_status, br_cond);
                if (flags_we) m_status = alu_zncv;
                case (dest)
                    2'b01: m_a = alu_out;
                    2'b10: m_b = alu_out;
                    2'b11: begin
                        m_mem_data = alu_out;
                        m_busy = 1;
                        m_wait = 0;
                    end
                    default: ;
                endcase
            end
        end
        #1;
        check("reg_a",    {24'd0, reg_a},    {24'd0, m_a});
        check("reg_b",    {24'd0, reg_b},    {24'd0, m_b});
        check("status",   {28'd0, status},   {28'd0, m_status});
        check("mem_data", {24'd0, mem_data}, {24'd0, m_mem_data});
        check("mem_we",   {31'd0, mem_we},   {31'd0, m_busy});
        check("br_taken", {31'd0, br_taken}, {31'd0, m_br});
        check("wb_err",   {31'd0, wb_err},   {31'd0, m_err});
    endtask

    initial begin
        int we_cycles;
        reset = 1'b1;
        idle_inputs();
        m_a = '0; m_b = '0; m_mem_data = '0; m_status = '0;
        m_busy = 0; m_err = 0; m_br = 0; m_wait = 0;
        step();
        step();
        check("rst_reg_a", {24'd0, reg_a}, 32'h0);
        check("rst_ready", {31'd0, in_ready}, 32'h0);
        reset = 1'b0;

        // Write reg_a with zero flags
        drive(1'b1, 8'h2A, 4'b0000, 2'b01, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        check("wr_reg_a", {24'd0, reg_a}, 32'h2A);
        check("wr_status", {28'd0, status}, 32'h0);

        // Set Z, then branch EQ while clearing flags in the same transaction
        drive(1'b1, 8'h00, 4'b1000, 2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b1, 8'h00, 4'b0000, 2'b00, 1'b1, 1'b1, 3'd1, 1'b0);
        step();
        check("br_eq_pulse", {31'd0, br_taken}, 32'h1);
        check("br_eq_status", {28'd0, status}, 32'h0);
        idle_inputs();
        step();
        check("br_one_cycle", {31'd0, br_taken}, 32'h0);

        // Memory write with three stalled cycles
        drive(1'b1, 8'h55, 4'b0000, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        we_cycles = int'(mem_we);
        drive(1'b1, 8'hAA, 4'b1111, 2'b01, 1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            we_cycles += int'(mem_we);
            check("mem_hold_data", {24'd0, mem_data}, 32'h55);
        end
        mem_ack = 1'b1;
        step();
        check("mem_we_cycles", we_cycles, 4);
        check("mem_done_we", {31'd0, mem_we}, 32'h0);
        check("mem_ignored_a", {24'd0, reg_a}, 32'h2A);
        idle_inputs();
        step();

        // Reset coincident with ack while a write is pending
        drive(1'b1, 8'h77, 4'b0110, 2'b11, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        reset = 1'b1;
        mem_ack = 1'b1;
        step();
        check("rst_mw_we", {31'd0, mem_we}, 32'h0);
        check("rst_mw_data", {24'd0, mem_data}, 32'h0);
        reset = 1'b0;
        idle_inputs();
        step();
        check("rst_mw_ready", {31'd0, in_ready}, 32'h1);

`ifdef WB_MEM_TIMEOUT_EN
        // Stalled write times out and latches the sticky error
        drive(1'b1, 8'h3C, 4'b0000, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        idle_inputs();
        we_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            we_cycles += int'(mem_we);
            step();
        end
        check("tmo_we_cycles", we_cycles, 16);
        check("tmo_we_low", {31'd0, mem_we}, 32'h0);
        check("tmo_err", {31'd0, wb_err}, 32'h1);
        for (int i = 0; i < 3; i++) step();
        check("tmo_err_sticky", {31'd0, wb_err}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("tmo_err_clear", {31'd0, wb_err}, 32'h0);
`endif

        // Back-to-back accepts
        drive(1'b1, 8'h01, 4'b0000, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b1, 8'h02, 4'b0000, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b1, 8'hFF, 4'b0000, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        check("b2b_reg_b", {24'd0, reg_b}, 32'h02);
        check("b2b_reg_a", {24'd0, reg_a}, {24'd0, m_a});

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_out  = 8'($urandom);
            alu_zncv = 4'($urandom);
            dest     = 2'($urandom);
            flags_we = 1'($urandom);
            br_req   = 1'($urandom);
            br_cond  = 3'($urandom);
            mem_ack  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
